oldland_prefetch: RTL and testbench

Parametrised successor to the single-entry Oldland fetch stage. It decouples instruction memory from decode with a DEPTH-entry prefetch FIFO, a valid/ready handshake to decode, and flush-on-redirect. It also supports precise instruction-fault tagging and debug run/stop draining. It sits between the instruction bus and oldland_decode.

---
 rtl/oldland_prefetch.sv | 144 ++++++++++++++
 tb/tb_oldland_prefetch.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oldland_prefetch.sv
// Instruction prefetch: DEPTH-entry FIFO between the instruction bus and decode, flushed on redirect.
// Head entry visible the cycle after its bus completion; issue stalls when the FIFO would fill, decode stalls via instr_ready.
`ifndef INSTR_NOP
`define INSTR_NOP 32'h00000000
`endif

module oldland_prefetch #(
    parameter logic [31:0] RESET_ADDR = 32'h00000000,
    parameter int          DEPTH      = 4,
    parameter logic [31:0] NOP_INSTR  = `INSTR_NOP
) (
    input  logic        clk,
    input  logic        rst,
    output logic        i_access,
    output logic [29:0] i_addr,
    input  logic        i_ack,
    input  logic        i_error,
    input  logic [31:0] i_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc_plus_4,
    output logic        instr_fault,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        run,
    output logic        stopped,
    output logic [31:0] dbg_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus_4;
        logic        fault;
    } entry_t;

    entry_t        r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_fetch_pc;
    logic          r_access;
    logic [29:0]   r_addr;
    logic          r_drop;
    logic          r_halted;
    logic          r_stopped;
    logic [31:0]   r_last_pc4;

    logic          w_done;
    logic          w_push;
    logic          w_pop;
    logic          w_pending;
    logic          w_issue;
    logic          w_drop_next;
    logic          w_halted_next;
    logic [CW-1:0] w_count_next;
    logic [31:0]   w_fetch_pc_plus_4;
    logic [31:0]   w_fetch_pc_next;
    entry_t        w_head;
    entry_t        w_new_entry;

    assign w_done            = r_access & (i_ack | i_error);
    assign w_push            = w_done & ~r_drop & ~redirect;
    assign w_pop             = instr_valid & instr_ready & ~redirect;
    assign w_pending         = r_access & ~w_done;
    assign w_fetch_pc_plus_4 = r_fetch_pc + 32'd4;
    assign w_head            = r_mem[r_rd_ptr];
    assign w_new_entry       = {(i_error ? NOP_INSTR : i_data), w_fetch_pc_plus_4, i_error};

    // Redirect flushes the FIFO outright, so a same-cycle push or pop never lands.
    assign w_count_next = redirect ? '0 : (r_count + CW'(w_push) - CW'(w_pop));

    assign w_fetch_pc_next = redirect ? (redirect_pc & 32'hffff_fffc) :
                             (w_push && !i_error) ? w_fetch_pc_plus_4 : r_fetch_pc;

    // An in-flight request orphaned by a redirect must still be waited out on the bus.
    assign w_drop_next = (redirect && w_pending) ? 1'b1 :
                         w_done                  ? 1'b0 : r_drop;

    assign w_halted_next = redirect ? 1'b0 :
                           (w_push && i_error) ? 1'b1 : r_halted;

    assign w_issue = run & ~w_halted_next & ~w_pending & ~w_drop_next &
                     (w_count_next < DEPTH_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_fetch_pc <= RESET_ADDR & 32'hffff_fffc;
            r_access   <= 1'b0;
            r_addr     <= '0;
            r_drop     <= 1'b0;
            r_halted   <= 1'b0;
            r_stopped  <= 1'b0;
            r_last_pc4 <= '0;
        end else begin
            r_count    <= w_count_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_drop     <= w_drop_next;
            r_halted   <= w_halted_next;
            r_access   <= w_issue | w_pending;
            if (w_issue) begin
                r_addr <= w_fetch_pc_next[31:2];
            end
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_new_entry;
            end
            if (redirect) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
            end
            if (instr_valid) begin
                r_last_pc4 <= w_head.pc_plus_4;
            end
            r_stopped <= ~r_access & (r_count == '0) & ~run;
        end
    end

    assign i_access        = r_access;
    assign i_addr          = r_addr;
    assign instr_valid     = (r_count != '0);
    assign instr           = instr_valid ? w_head.instr : NOP_INSTR;
    assign instr_fault     = instr_valid & w_head.fault;
    assign instr_pc_plus_4 = instr_valid ? w_head.pc_plus_4 : r_last_pc4;
    assign stopped         = r_stopped;
    assign dbg_pc          = instr_valid ? (w_head.pc_plus_4 - 32'd4) : r_fetch_pc;

endmodule

// File: tb/tb_oldland_prefetch.sv
// Directed bench for oldland_prefetch with a latency-programmable instruction bus model.
module tb_oldland_prefetch;

    localparam logic [31:0] NOP = 32'hF00D_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_access;
    logic [29:0] i_addr;
    logic        i_ack = 1'b0;
    logic        i_error = 1'b0;
    logic [31:0] i_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc_plus_4;
    logic        instr_fault;
    logic        instr_valid;
    logic        instr_ready;
    logic        run;
    logic        stopped;
    logic [31:0] dbg_pc;

    int          n_checks = 0;
    int          n_errors = 0;
    int          bus_lat = 0;
    int          wcnt = 0;
    logic        err_on = 1'b0;
    logic [29:0] err_addr = '0;

    oldland_prefetch #(
        .RESET_ADDR(32'h0000_0100),
        .DEPTH     (4),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_access       (i_access),
        .i_addr         (i_addr),
        .i_ack          (i_ack),
        .i_error        (i_error),
        .i_data         (i_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .instr          (instr),
        .instr_pc_plus_4(instr_pc_plus_4),
        .instr_fault    (instr_fault),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .run            (run),
        .stopped        (stopped),
        .dbg_pc         (dbg_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    assign i_data = dat({i_addr, 2'b00});

    // Bus responder: completes a request bus_lat cycles after it is first seen.
    always @(negedge clk) begin
        if (i_ack || i_error) wcnt = 0;
        if (i_access && !rst) begin
            if (wcnt >= bus_lat) begin
                if (err_on && i_addr == err_addr) begin
                    i_error = 1'b1;
                    i_ack   = 1'b0;
                end else begin
                    i_ack   = 1'b1;
                    i_error = 1'b0;
                end
            end else begin
                i_ack   = 1'b0;
                i_error = 1'b0;
            end
            wcnt++;
        end else begin
            i_ack   = 1'b0;
            i_error = 1'b0;
            wcnt    = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        run = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0; rst = 1'b0;
        #2 rst = 1'b1;
        tick();
        chk("rst_access", i_access, 1'b0);
        chk("rst_addr", i_addr, 30'h0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc4", instr_pc_plus_4, 32'h0);
        chk("rst_fault", instr_fault, 1'b0);
        chk("rst_stopped", stopped, 1'b0);
        chk("rst_dbg_pc", dbg_pc, 32'h100);
        tick();
        rst = 1'b0;

        // Streaming, zero-wait bus
        tick();
        chk("e1_access", i_access, 1'b1);
        chk("e1_addr", i_addr, 30'h40);
        chk("e1_valid", instr_valid, 1'b0);
        tick();
        chk("e2_addr", i_addr, 30'h41);
        chk("e2_valid", instr_valid, 1'b1);
        chk("e2_pc4", instr_pc_plus_4, 32'h104);
        chk("e2_instr", instr, dat(32'h100));
        tick();
        chk("e3_addr", i_addr, 30'h42);
        chk("e3_pc4", instr_pc_plus_4, 32'h108);
        chk("e3_instr", instr, dat(32'h104));

        // Decode stalled: FIFO fills and issue stops
        instr_ready = 1'b0;
        tick(); tick(); tick();
        chk("full_access", i_access, 1'b0);
        chk("full_valid", instr_valid, 1'b1);
        chk("full_pc4", instr_pc_plus_4, 32'h108);
        tick();
        chk("full_hold_access", i_access, 1'b0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("pop1_access", i_access, 1'b1);
        chk("pop1_addr", i_addr, 30'h45);
        chk("pop1_pc4", instr_pc_plus_4, 32'h10c);
        tick();
        chk("refill_access", i_access, 1'b0);
        tick();
        chk("refill_hold_access", i_access, 1'b0);
        chk("refill_pc4", instr_pc_plus_4, 32'h10c);

        // Redirect while a 3-cycle request is outstanding
        bus_lat = 3; instr_ready = 1'b1;
        tick();
        chk("lat_access", i_access, 1'b1);
        chk("lat_addr", i_addr, 30'h46);
        chk("lat_pc4", instr_pc_plus_4, 32'h110);
        chk("lat_instr", instr, dat(32'h10c));
        redirect = 1'b1; redirect_pc = 32'h0000_2003;
        tick();
        redirect = 1'b0;
        chk("rd_valid", instr_valid, 1'b0);
        chk("rd_instr", instr, NOP);
        chk("rd_access_held", i_access, 1'b1);
        chk("rd_addr_held", i_addr, 30'h46);
        tick(); tick();
        chk("drop_valid", instr_valid, 1'b0);
        chk("drop_addr", i_addr, 30'h46);
        tick();
        chk("new_access", i_access, 1'b1);
        chk("new_addr", i_addr, 30'h800);
        chk("new_valid", instr_valid, 1'b0);
        tick(); tick(); tick();
        chk("new_wait_valid", instr_valid, 1'b0);
        tick();
        chk("new_head_valid", instr_valid, 1'b1);
        chk("new_head_pc4", instr_pc_plus_4, 32'h2004);
        chk("new_head_instr", instr, dat(32'h2000));

        // Bus error at 0x300
        bus_lat = 0; redirect = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect = 1'b0; err_on = 1'b1; err_addr = 30'hC0;
        chk("err_req_addr", i_addr, 30'hC0);
        chk("err_req_valid", instr_valid, 1'b0);
        tick();
        chk("err_valid", instr_valid, 1'b1);
        chk("err_fault", instr_fault, 1'b1);
        chk("err_instr", instr, NOP);
        chk("err_pc4", instr_pc_plus_4, 32'h304);
        chk("err_access", i_access, 1'b0);
        chk("err_dbg_pc", dbg_pc, 32'h300);
        tick();
        chk("err_pop_valid", instr_valid, 1'b0);
        chk("err_pop_fault", instr_fault, 1'b0);
        chk("err_pop_pc4", instr_pc_plus_4, 32'h304);
        chk("err_halt_access", i_access, 1'b0);
        tick();
        chk("err_halt2_access", i_access, 1'b0);
        chk("err_halt_dbg", dbg_pc, 32'h300);
        err_on = 1'b0; redirect = 1'b1; redirect_pc = 32'h400;
        tick();
        redirect = 1'b0; instr_ready = 1'b0;
        chk("resume_access", i_access, 1'b1);
        chk("resume_addr", i_addr, 30'h100);

        // Stop with buffered entries and one outstanding
        tick(); tick();
        chk("stop_pre_addr", i_addr, 30'h102);
        run = 1'b0;
        tick();
        chk("stop_access", i_access, 1'b0);
        chk("stop_valid", instr_valid, 1'b1);
        chk("stop_pc4", instr_pc_plus_4, 32'h404);
        chk("stop_instr", instr, dat(32'h400));
        chk("stop_dbg", dbg_pc, 32'h400);
        chk("stop_not_yet", stopped, 1'b0);
        tick();
        chk("stop_not_yet2", stopped, 1'b0);
        instr_ready = 1'b1;
        tick(); tick(); tick();
        chk("drain_valid", instr_valid, 1'b0);
        chk("drain_stopped", stopped, 1'b0);
        chk("drain_dbg", dbg_pc, 32'h40c);
        tick();
        chk("stopped_high", stopped, 1'b1);
        chk("stopped_access", i_access, 1'b0);
        run = 1'b1;
        tick();
        chk("run_stopped", stopped, 1'b0);
        chk("run_access", i_access, 1'b1);
        chk("run_addr", i_addr, 30'h103);

        // Address wrap at the top of memory
        redirect = 1'b1; redirect_pc = 32'hffff_fff8;
        tick();
        redirect = 1'b0;
        chk("wrap_addr0", i_addr, 30'h3fff_fffe);
        chk("wrap_valid0", instr_valid, 1'b0);
        tick();
        chk("wrap_pc4a", instr_pc_plus_4, 32'hffff_fffc);
        chk("wrap_addr1", i_addr, 30'h3fff_ffff);
        tick();
        chk("wrap_pc4b", instr_pc_plus_4, 32'h0);
        chk("wrap_instr", instr, dat(32'hffff_fffc));
        chk("wrap_addr2", i_addr, 30'h0);
        chk("wrap_dbg", dbg_pc, 32'hffff_fffc);
        bus_lat = 3;
        tick();
        chk("mid_access", i_access, 1'b1);
        chk("mid_valid", instr_valid, 1'b0);

        // Reset in the middle of a request
        rst = 1'b1;
        #1;
        chk("mrst_access", i_access, 1'b0);
        chk("mrst_pc4", instr_pc_plus_4, 32'h0);
        chk("mrst_dbg", dbg_pc, 32'h100);
        bus_lat = 0;
        tick();
        chk("mrst_hold_access", i_access, 1'b0);
        rst = 1'b0;
        tick();
        chk("refetch_access", i_access, 1'b1);
        chk("refetch_addr", i_addr, 30'h40);
        tick();
        chk("refetch_valid", instr_valid, 1'b1);
        chk("refetch_pc4", instr_pc_plus_4, 32'h104);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
